alu_req_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared 32-bit ALU, including its comparison sub-unit. It accepts operation requests from two clients: port 0 (EX-stage branch/compare) and port 1 (multi-cycle helper unit). It grants one request at a time, drives the ALU from registered operands, captures the ALU result, and returns it to the granted client over a valid/ready response handshake. It sits between the clients and the combinational ALU, so no client drives the ALU directly.

---
 rtl/alu_req_arb.sv | 144 ++++++++++++++
 tb/tb_alu_req_arb.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arb.sv
// Two-port request arbiter/sequencer in front of the shared combinational ALU.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties); default is round-robin.
module alu_req_arb #(
  parameter int DW = 32,
  parameter int FW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid0,
  input  logic          req_valid1,
  output logic          req_ready0,
  output logic          req_ready1,
  input  logic [DW-1:0] req_a0,
  input  logic [DW-1:0] req_b0,
  input  logic [DW-1:0] req_a1,
  input  logic [DW-1:0] req_b1,
  input  logic [FW-1:0] req_fun0,
  input  logic [FW-1:0] req_fun1,
  input  logic          req_sign0,
  input  logic          req_sign1,
  output logic          rsp_valid0,
  output logic          rsp_valid1,
  input  logic          rsp_ready0,
  input  logic          rsp_ready1,
  output logic [DW-1:0] rsp_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [FW-1:0] alu_fun,
  output logic          alu_sign,
  input  logic [DW-1:0] alu_s,
  output logic          busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. Requesters hold valid (and payload) until ready; the arbiter
  // holds rsp_valid and rsp_data until the owning client's rsp_ready.

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [FW-1:0] fun_q, fun_d;
  logic          sign_q, sign_d;
  logic          owner_q, owner_d;
  logic          grant0, grant1;
  logic          accept, rsp_take;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant0 = req_valid0;
    grant1 = req_valid1 & ~req_valid0;
  end
`else
  logic last_q, last_d;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant0 = req_valid0 & (~req_valid1 | last_q);
    grant1 = req_valid1 & (~req_valid0 | ~last_q);
  end
`endif

  assign accept   = (state_q == IDLE) & ~reset & (grant0 | grant1);
  assign rsp_take = owner_q ? rsp_ready1 : rsp_ready0;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    fun_d      = fun_q;
    sign_d     = sign_q;
    owner_d    = owner_q;
    data_d     = data_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_d     = last_q;
`endif
    req_ready0 = 1'b0;
    req_ready1 = 1'b0;
    rsp_valid0 = 1'b0;
    rsp_valid1 = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready0 = ~reset & grant0;
        req_ready1 = ~reset & grant1;
        if (accept) begin
          state_d = EXEC;
          owner_d = grant1;
          a_d     = grant1 ? req_a1 : req_a0;
          b_d     = grant1 ? req_b1 : req_b0;
          fun_d   = grant1 ? req_fun1 : req_fun0;
          sign_d  = grant1 ? req_sign1 : req_sign0;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_d  = grant1;
`endif
        end
      end
      EXEC: begin
        data_d  = alu_s;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid0 = ~owner_q;
        rsp_valid1 = owner_q;
        if (rsp_take) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      sign_q  <= 1'b0;
      owner_q <= 1'b0;
      data_q  <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      sign_q  <= sign_d;
      owner_q <= owner_d;
      data_q  <= data_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  // ALU inputs come straight from the operand registers so they hold through IDLE.
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_fun  = fun_q;
  assign alu_sign = sign_q;
  assign rsp_data = data_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_req_arb.sv
// Self-checking bench for alu_req_arb: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_alu_req_arb;
  localparam int W = 32;

  logic         clk, reset;
  logic         req_valid0, req_valid1, req_ready0, req_ready1;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [5:0]   req_fun0, req_fun1;
  logic         req_sign0, req_sign1;
  logic         rsp_valid0, rsp_valid1, rsp_ready0, rsp_ready1;
  logic [W-1:0] rsp_data, alu_a, alu_b, alu_s;
  logic [5:0]   alu_fun;
  logic         alu_sign, busy;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int acc_q[$];
  int acc_cyc_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sb_exp;

  alu_req_arb #(.DW(32), .FW(6)) dut (
    .clk(clk), .reset(reset),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_fun0(req_fun0), .req_fun1(req_fun1),
    .req_sign0(req_sign0), .req_sign1(req_sign1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_ready0(rsp_ready0), .rsp_ready1(rsp_ready1),
    .rsp_data(rsp_data), .alu_a(alu_a), .alu_b(alu_b),
    .alu_fun(alu_fun), .alu_sign(alu_sign), .alu_s(alu_s), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- attached ALU ----------------
  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [5:0] f, input logic s);
    logic lt;
    lt = s ? ($signed(a) < $signed(b)) : (a < b);
    case (f[5:4])
      2'b00: return f[0] ? a - b : a + b;
      2'b01: return a ^ b;
      2'b10: return a << b[4:0];
      default: begin
        case (f[3:1])
          3'b001: return {31'd0, a == b};
          3'b000: return {31'd0, a != b};
          3'b010: return {31'd0, lt};
          3'b101: return {31'd0, $signed(a) <= 0};
          3'b110: return {31'd0, a[31]};
          3'b111: return {31'd0, $signed(a) > 0};
          default: return '0;
        endcase
      end
    endcase
  endfunction

  assign alu_s = alu_fn(alu_a, alu_b, alu_fun, alu_sign);

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level model ----------------
  function automatic int model_grant(input logic v0, input logic v1, input int last);
    if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (last == 0) ? 1 : 0;
`endif
    end
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  bit           m_act  = 0;
  int           m_age  = 0;
  int           m_own  = 0;
  int           m_last = 1;
  logic [W-1:0] m_a = '0, m_b = '0, m_data = '0, m_res = '0;
  logic [5:0]   m_fun = '0;
  logic         m_sign = 1'b0;
  int           g;

  always @(negedge clk) begin
    g = (!reset && !m_act) ? model_grant(req_valid0, req_valid1, m_last) : -1;
    chk("req_ready0", req_ready0, W'(g == 0));
    chk("req_ready1", req_ready1, W'(g == 1));
    chk("rsp_valid0", rsp_valid0, W'(m_act && m_age >= 2 && m_own == 0));
    chk("rsp_valid1", rsp_valid1, W'(m_act && m_age >= 2 && m_own == 1));
    chk("busy", busy, W'(m_act));
    chk("rsp_data", rsp_data, m_data);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_fun", W'(alu_fun), W'(m_fun));
    chk("alu_sign", W'(alu_sign), W'(m_sign));
    if (reset) begin
      m_act = 0; m_last = 1; m_a = '0; m_b = '0; m_fun = '0; m_sign = 0; m_data = '0;
    end else if (!m_act) begin
      if (g >= 0) begin
        m_a    = (g == 1) ? req_a1 : req_a0;
        m_b    = (g == 1) ? req_b1 : req_b0;
        m_fun  = (g == 1) ? req_fun1 : req_fun0;
        m_sign = (g == 1) ? req_sign1 : req_sign0;
        m_res  = alu_fn(m_a, m_b, m_fun, m_sign);
        m_own  = g; m_last = g; m_act = 1; m_age = 1;
      end
    end else if (m_age == 1) begin
      m_data = m_res;
      m_age  = 2;
    end else if ((m_own == 0 && rsp_ready0) || (m_own == 1 && rsp_ready1)) begin
      m_act = 0;
    end
  end

  // ---------------- accept log and result scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && req_valid0 && req_ready0) begin acc_q.push_back(0); acc_cyc_q.push_back(cyc); end
    if (!reset && req_valid1 && req_ready1) begin acc_q.push_back(1); acc_cyc_q.push_back(cyc); end
    if (!reset && rsp_valid1 && rsp_ready1 && exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      chk("b2b_result", rsp_data, sb_exp);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int n);
    for (int k = 0; k < 60 && acc_q.size() < n; k++) begin
      @(negedge clk);
      #1;
    end
    if (acc_q.size() < n) begin
      checks++; fails++;
      $display("FAIL wait_accept: got %0d accepts expected %0d", acc_q.size(), n);
    end
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (k == 40) begin
      checks++; fails++;
      $display("FAIL drain: got busy=1 expected busy=0 within 40 cycles");
    end
  endtask

  task automatic reset_tie_check(input string tag);
    int n0;
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_valid0"}, rsp_valid0, 0);
    chk({tag, "_rsp_valid1"}, rsp_valid1, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_fun"}, W'(alu_fun), 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    n0 = acc_q.size();
    step();
    req_valid0 = 1; req_a0 = 2; req_b0 = 2; req_fun0 = 6'b000000; req_sign0 = 0;
    req_valid1 = 1; req_a1 = 4; req_b1 = 1; req_fun1 = 6'b000001; req_sign1 = 0;
    rsp_ready0 = 1; rsp_ready1 = 1;
    @(negedge clk);
    chk({tag, "_tie_ready0"}, req_ready0, 1);
    chk({tag, "_tie_ready1"}, req_ready1, 0);
    wait_acc(n0 + 1);
    step(); req_valid0 = 0;
    wait_acc(n0 + 2);
    step(); req_valid1 = 0;
    drain();
  endtask

  logic [W-1:0] ta[4] = '{32'd10, 32'd50, 32'd7, 32'd3};
  logic [W-1:0] tb[4] = '{32'd20, 32'd8, 32'd7, 32'd2};
  logic [5:0]   tf[4] = '{6'b000000, 6'b000001, 6'b110011, 6'b110101};
  int           exp_tie[4];

  // ---------------- directed stimulus ----------------
  initial begin
    int n0;
    reset = 1;
    req_valid0 = 0; req_valid1 = 0; rsp_ready0 = 0; rsp_ready1 = 0;
    req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
    req_fun0 = 0; req_fun1 = 0; req_sign0 = 0; req_sign1 = 0;
    repeat (3) step();
    reset = 0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_alu_b", alu_b, 0);

    // single op: 5 < 7 signed
    step();
    req_valid0 = 1; req_a0 = 5; req_b0 = 7; req_fun0 = 6'b110101; req_sign0 = 1; rsp_ready0 = 1;
    @(negedge clk);
    chk("single_ready0", req_ready0, 1);
    chk("single_ready1", req_ready1, 0);
    step(); req_valid0 = 0;
    @(negedge clk);
    chk("single_exec_valid", rsp_valid0, 0);
    chk("single_exec_busy", busy, 1);
    step();
    @(negedge clk);
    chk("single_rsp_valid", rsp_valid0, 1);
    chk("single_rsp_data", rsp_data, 1);
    step();
    @(negedge clk);
    chk("single_idle", busy, 0);

    // continuous tie right after reset
    step(); reset = 1;
    step(); reset = 0;
    acc_q.delete(); acc_cyc_q.delete();
    req_valid0 = 1; req_a0 = 3; req_b0 = 4; req_fun0 = 6'b000000; req_sign0 = 0;
    req_valid1 = 1; req_a1 = 9; req_b1 = 1; req_fun1 = 6'b000001; req_sign1 = 0;
    rsp_ready0 = 1; rsp_ready1 = 1;
    wait_acc(4);
    step(); req_valid0 = 0; req_valid1 = 0;
    drain();
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_tie = '{0, 0, 0, 0};
`else
    exp_tie = '{0, 1, 0, 1};
`endif
    if (acc_q.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk($sformatf("tie_order%0d", k), W'(acc_q[k]), W'(exp_tie[k]));
      chk("tie_gap", W'(acc_cyc_q[1] - acc_cyc_q[0]), 3);
    end

    // backpressure on port 1: -3 <= 0
    n0 = acc_q.size();
    step();
    req_valid1 = 1; req_a1 = 32'hFFFF_FFFD; req_b1 = 0; req_fun1 = 6'b111011; req_sign1 = 1;
    rsp_ready1 = 0; rsp_ready0 = 1;
    wait_acc(n0 + 1);
    chk("bp_accept_ready1", req_ready1, 1);
    step();
    req_valid1 = 0;
    req_valid0 = 1; req_a0 = 1; req_b0 = 2; req_fun0 = 6'b000000; req_sign0 = 0;
    step();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid1", rsp_valid1, 1);
      chk("bp_rsp_valid0", rsp_valid0, 0);
      chk("bp_rsp_data", rsp_data, 1);
      chk("bp_ready0", req_ready0, 0);
      chk("bp_ready1", req_ready1, 0);
      step();
    end
    rsp_ready1 = 1;
    wait_acc(n0 + 2);
    if (acc_q.size() >= n0 + 2) chk("bp_next_port", W'(acc_q[n0 + 1]), 0);
    step(); req_valid0 = 0;
    drain();

    // operand stability: 100 + 23, operand changed after accept
    n0 = acc_q.size();
    step();
    req_valid0 = 1; req_a0 = 100; req_b0 = 23; req_fun0 = 6'b000000; req_sign0 = 0;
    wait_acc(n0 + 1);
    step(); req_valid0 = 0; req_a0 = 999;
    @(negedge clk);
    chk("stab_alu_a", alu_a, 100);
    step();
    @(negedge clk);
    chk("stab_rsp_valid0", rsp_valid0, 1);
    chk("stab_rsp_data", rsp_data, 123);
    drain();

    // reset during EXEC (port 0 in flight, so last points at 0 before reset)
    n0 = acc_q.size();
    step();
    req_valid0 = 1; req_a0 = 8; req_b0 = 8; req_fun0 = 6'b110011; req_sign0 = 0;
    wait_acc(n0 + 1);
    step(); req_valid0 = 0; reset = 1;
    step(); reset = 0;
    @(negedge clk);
    reset_tie_check("rst_exec");

    // reset during RESP (port 1 waiting on backpressure)
    n0 = acc_q.size();
    step();
    req_valid1 = 1; req_a1 = 1; req_b1 = 1; req_fun1 = 6'b110011; req_sign1 = 0; rsp_ready1 = 0;
    wait_acc(n0 + 1);
    step(); req_valid1 = 0;
    step(); reset = 1;
    step(); reset = 0;
    @(negedge clk);
    reset_tie_check("rst_resp");

    // back-to-back port 1 only
    exp_q.push_back(32'd30);
    exp_q.push_back(32'd42);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    n0 = acc_q.size();
    step();
    rsp_ready1 = 1; req_valid1 = 1;
    for (int i = 0; i < 4; i++) begin
      req_a1 = ta[i]; req_b1 = tb[i]; req_fun1 = tf[i]; req_sign1 = 0;
      wait_acc(n0 + i + 1);
      step();
    end
    req_valid1 = 0;
    drain();
    if (acc_cyc_q.size() >= n0 + 4)
      for (int i = 0; i < 3; i++)
        chk($sformatf("b2b_gap%0d", i), W'(acc_cyc_q[n0 + i + 1] - acc_cyc_q[n0 + i]), 3);
    chk("b2b_drained", W'(exp_q.size()), 0);

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
